mac_requantizer: RTL and testbench

- Output stage that consumes the wide signed accumulator results produced by the MAC datapath.
- Converts each result back into a K-bit signed activation: optional ReLU, rounding arithmetic right shift, then saturation.
- Two-stage pipeline with valid/ready handshake on both sides, so requantized activations can be fed to the next layer's MAC input under backpressure.
- Keeps a running saturation counter for debug and calibration.

---
 rtl/mac_requantizer.sv | 128 ++++++++++++
 tb/tb_mac_requantizer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_requantizer.sv
// mac_requantizer: ReLU, rounding shift and saturation of MAC results
// back to K-bit activations, through a two-stage valid/ready pipeline.
module mac_requantizer #(
  parameter int N         = 8,
  parameter int B         = 8,
  parameter int K         = 8,
  parameter int RES_WIDTH =
    $clog2(((2**K)-1)*((2**N)-1)+2**B),
  parameter int SHIFT_W   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RES_WIDTH-1:0] in_data,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic                 relu_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K-1:0]         out_data,
  output logic                 sat_flag,
  input  logic                 sat_clr,
  output logic [CNT_W-1:0]     sat_count
);

  // Two guard bits keep x + 2^(shift-1) exact up to shift = RES_WIDTH+1.
  localparam int XW = RES_WIDTH + 2;

  localparam logic signed [XW-1:0] QMAX =
    XW'((2**(K-1))-1);
  localparam logic signed [XW-1:0] QMIN =
    XW'(-(2**(K-1)));

  typedef struct packed {
    logic [RES_WIDTH-1:0] x;
    logic [SHIFT_W-1:0]   sh;
    logic                 relu;
  } s1_t;

  typedef struct packed {
    logic [K-1:0] q;
    logic         sat;
  } rq_t;

  s1_t  s1_q;
  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic s1_take;
  logic sat_inc;
  rq_t  rq;

  logic signed [XW-1:0] r;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] y;

  assign s2_free   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign s1_take   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign sat_inc   = s2_free && s1_valid && rq.sat;

  always_comb begin
    r = {{(XW-RES_WIDTH){s1_q.x[RES_WIDTH-1]}},
         s1_q.x};
    if (s1_q.relu && s1_q.x[RES_WIDTH-1]) begin
      r = '0;
    end
    rnd = '0;
    if (s1_q.sh != '0) begin
      rnd = XW'(1) << (s1_q.sh - SHIFT_W'(1));
    end
    y = (r + rnd) >>> s1_q.sh;
    // Past RES_WIDTH the rounded quotient is always exactly zero.
    if (int'(s1_q.sh) > RES_WIDTH) begin
      y = '0;
    end
    rq.q   = y[K-1:0];
    rq.sat = 1'b0;
    if (y > QMAX) begin
      rq.q   = QMAX[K-1:0];
      rq.sat = 1'b1;
    end else if (y < QMIN) begin
      rq.q   = QMIN[K-1:0];
      rq.sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_take) begin
      s1_valid <= 1'b1;
      s1_q     <= '{x: in_data,
                    sh: shift,
                    relu: relu_en};
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= rq.q;
        sat_flag <= rq.sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (sat_inc && sat_count != '1) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mac_requantizer.sv
// tb_mac_requantizer: directed and random checks of the requantizer
// pipeline, handshake and saturation counter.
module tb_mac_requantizer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic [3:0]    shift;
  logic          relu_en;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          sat_flag;
  logic          sat_clr;
  logic [CW-1:0] sat_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       s;
  } exp_t;

  mac_requantizer #(.CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .shift(shift),
    .relu_en(relu_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .sat_flag(sat_flag),
    .sat_clr(sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(
    input  logic [15:0] x,
    input  int          sh,
    input  logic        relu,
    output logic [7:0]  d,
    output logic        s
  );
    longint v;
    v = longint'($signed(x));
    if (relu && v < 0) v = 0;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    s = 1'b1;
    if (v > 127) d = 8'd127;
    else if (v < -128) d = 8'h80;
    else begin
      d = 8'(v);
      s = 1'b0;
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    shift = '0;
    relu_en = 1'b0;
    out_ready = 1'b1;
    sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%0d exp v=0 d=0",
               out_valid, out_data);
    end
    checks++;
    if (sat_flag !== 1'b0 || sat_count !== '0) begin
      errors++;
      $display("FAIL reset_sat: got f=%b c=%0d exp 0 0",
               sat_flag, sat_count);
    end
    rst_n = 1'b1;
    #3;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
    tick();
  endtask

  task automatic test_latency();
    in_valid = 1'b1;
    in_data = 16'd256;
    shift = 4'd2;
    relu_en = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_c0: out_valid got %b exp 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_c1: out_valid got %b exp 0", out_valid);
    end
    tick();
    #3;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd64 ||
        sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL lat_c2: got v=%b d=%0d s=%b exp 1 64 0",
               out_valid, $signed(out_data), sat_flag);
    end
    tick();
  endtask

  task automatic test_rounding();
    int xs [4] = '{6, -6, 5, -5};
    int ex [4] = '{2, -1, 1, -1};
    logic [7:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_data = (i < 4) ? 16'(xs[i]) : 16'hDEAD;
      shift = 4'd2;
      relu_en = 1'b0;
      #3;
      if (i >= 2) begin
        e = 8'(ex[i-2]);
        checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
          errors++;
          $display("FAIL round_%0d: got v=%b d=%0d exp 1 %0d",
                   i - 2, out_valid, $signed(out_data), ex[i-2]);
        end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    int xs [3] = '{32767, -300, -5};
    bit rl [3] = '{1'b0, 1'b0, 1'b1};
    int ex [3] = '{127, -128, 0};
    bit sx [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] e;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      in_data = (i < 3) ? 16'(xs[i]) : 16'h0;
      shift = 4'd0;
      relu_en = (i < 3) ? rl[i] : 1'b0;
      #3;
      if (i >= 2) begin
        e = 8'(ex[i-2]);
        checks++;
        if (out_valid !== 1'b1 || out_data !== e ||
            sat_flag !== sx[i-2]) begin
          errors++;
          $display("FAIL sat_%0d: got v=%b d=%0d s=%b exp 1 %0d %b",
                   i - 2, out_valid, $signed(out_data), sat_flag,
                   ex[i-2], sx[i-2]);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #3;
    checks++;
    if (sat_count !== CW'(2)) begin
      errors++;
      $display("FAIL sat_count: got %0d exp 2", sat_count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int vals [3] = '{10, 20, 30};
    out_ready = 1'b0;
    shift = 4'd0;
    relu_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 16'(vals[i]);
      #3;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept_%0d: in_ready got %b exp 1",
                 i, in_ready);
      end
      tick();
    end
    in_data = 16'd30;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== 8'd10) begin
        errors++;
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b d=%0d exp 0 1 10",
                 i, in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_data !== 8'd10) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b d=%0d exp 1 10",
               in_ready, out_data);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #3;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(vals[i])) begin
        errors++;
        $display("FAIL bp_order_%0d: got v=%b d=%0d exp 1 %0d",
                 i, out_valid, out_data, vals[i]);
      end
      tick();
    end
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: out_valid got %b exp 0", out_valid);
    end
    tick();
  endtask

  task automatic test_streaming();
    exp_t q [$];
    exp_t e;
    int sent = 0;
    int p2 = 0;
    int rdy_bad = 0;
    int vld_bad = 0;
    int cyc = 0;
    while ((sent < 100 || q.size() > 0) && cyc < 2000) begin
      if (sent < 100) begin
        in_valid = (sent >= 60) ? 1'b1 : 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) in_data = 16'($urandom);
      else in_data = 16'($urandom_range(0, 2047)) - 16'd1024;
      shift = 4'($urandom_range(0, 15));
      relu_en = 1'($urandom_range(0, 1));
      out_ready = (sent >= 60) ? 1'b1 : 1'($urandom_range(0, 1));
      #3;
      if (sent >= 60 && sent < 100) begin
        if (in_ready !== 1'b1) rdy_bad++;
        if (p2 >= 2 && out_valid !== 1'b1) vld_bad++;
        p2++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got d=%0d exp no output",
                   $signed(out_data));
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || sat_flag !== e.s) begin
            errors++;
            $display("FAIL stream_data: got d=%0d s=%b exp %0d %b",
                     $signed(out_data), sat_flag, $signed(e.d), e.s);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, int'(shift), relu_en, e.d, e.s);
        q.push_back(e);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != 100 || q.size() != 0) begin
      errors++;
      $display("FAIL stream_done: got sent=%0d left=%0d exp 100 0",
               sent, q.size());
    end
    checks++;
    if (rdy_bad != 0 || vld_bad != 0) begin
      errors++;
      $display("FAIL stream_rate: got stalls rdy=%0d vld=%0d exp 0 0",
               rdy_bad, vld_bad);
    end
  endtask

  task automatic test_counter();
    out_ready = 1'b1;
    in_valid = 1'b0;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    #3;
    checks++;
    if (sat_count !== '0) begin
      errors++;
      $display("FAIL cnt_clr: got %0d exp 0", sat_count);
    end
    tick();
    in_data = 16'h7FFF;
    shift = 4'd0;
    relu_en = 1'b0;
    in_valid = 1'b1;
    repeat (16) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #3;
    checks++;
    if (sat_count !== CW'(15)) begin
      errors++;
      $display("FAIL cnt_stick: got %0d exp 15", sat_count);
    end
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    #3;
    checks++;
    if (sat_count !== '0 || out_valid !== 1'b1 ||
        out_data !== 8'd127 || sat_flag !== 1'b1) begin
      errors++;
      $display("FAIL cnt_clr_wins: got c=%0d v=%b d=%0d s=%b exp 0 1 127 1",
               sat_count, out_valid, out_data, sat_flag);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    int bad = 0;
    out_ready = 1'b0;
    shift = 4'd0;
    relu_en = 1'b0;
    in_valid = 1'b1;
    in_data = 16'd5;
    tick();
    in_data = 16'd7;
    tick();
    in_valid = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd5) begin
      errors++;
      $display("FAIL rst_pre: got v=%b d=%0d exp 1 5",
               out_valid, out_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: got v=%b d=%0d rdy=%b exp 0 0 1",
               out_valid, out_data, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_no_output: got %0d valid cycles exp 0", bad);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_streaming();
    test_counter();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
